shift_add_mult: RTL
===================

Name: shift_add_mult

Overview:
Sequential unsigned multiplier that sits directly upstream of adder8 and is its only driver. It computes op_a * op_b by shift-and-add, one partial-product add per clock. Each cycle it feeds the running high half and the multiplicand to one adder8 instance (add mode, control tied 0). It exposes a start/busy/done handshake to the controlling datapath.

Parameters:
WIDTH, 8, operand width; product is 2*WIDTH bits; must match the adder8 instance WIDTH.

Ports:
clk      input   1          system clock, all state updates on rising edge
reset    input   1          asynchronous, active-high; clears all state immediately
start    input   1          request; sampled only in S_IDLE or S_DONE
op_a     input   WIDTH      multiplicand, captured on start acceptance
op_b     input   WIDTH      multiplier, captured on start acceptance
busy     output  1          high while in S_RUN
done     output  1          high for exactly the one cycle spent in S_DONE
product  output  2*WIDTH    result; valid when done=1, held until next start accepted

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - State -> S_IDLE.
  - busy=0, done=0, product=0, internal multiplicand/hi/lo/count=0.
  - The in-flight operation is discarded.
- States: S_IDLE, S_RUN, S_DONE.
- Start acceptance (S_IDLE or S_DONE, start=1 at an edge):
  - mcand<=op_a, hi<=0, lo<=op_b, count<=WIDTH.
  - State -> S_RUN.
  - done drops in the same edge if leaving S_DONE, so back-to-back operations are legal.
- S_RUN, each edge:
  - addend = lo[0] ? mcand : 0, driven to the adder8 op2; adder8 op1 = hi; control = 0.
  - Carry-out is not provided by adder8 and is derived combinationally: c = (hi[MSB] & addend[MSB]) | ((hi[MSB] | addend[MSB]) & ~sum[MSB]).
  - {hi, lo} <= {c, sum, lo} >> 1, i.e. hi<={c,sum[WIDTH-1:1]}, lo<={sum[0],lo[WIDTH-1:1]}.
  - count <= count-1.
  - When count==1 at the edge, state -> S_DONE and product <= the post-shift {hi, lo}.
- S_DONE:
  - done=1 for this cycle.
  - start=1 -> S_RUN (new operands captured); otherwise -> S_IDLE.
- Latency: exactly WIDTH edges in S_RUN.
  - If start is accepted at edge N, done is high in the cycle after edge N+WIDTH.
  - busy is high from edge N to edge N+WIDTH.
- start while busy=1 is ignored; operands are not re-captured and the result is unaffected.
- op_a/op_b are don't-care after the capturing edge.
- product is stable from the edge entering S_DONE until the next start-accepting edge. In S_IDLE it keeps the last result; it is 0 after reset.
- Arithmetic is unsigned modulo 2^(2*WIDTH); overflow cannot occur. Max WIDTH=8 result is 0xFE01.

Decomposition:
- Package mult_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mult_state_t.
  - localparam DEFAULT_WIDTH = 8.
- Count register width is $clog2(WIDTH+1), computed locally.
- One sub-module: the existing adder8 (instance name u_add), WIDTH passed through, control tied 1'b0.
- Carry derivation and shift are inline logic in shift_add_mult; no further sub-modules.

Test Plan:
- Reset, then start with op_a=3, op_b=5 -> busy for 8 cycles; done pulses 1 cycle; product=0x000F.
- op_a=0xFF, op_b=0xFF (exercises derived carry every step) -> product=0xFE01 when done.
- op_a=0x00, op_b=0xA7, then op_a=0xA7, op_b=0x00 -> product=0x0000 both times; latency still exactly 8 cycles.
- Start 0x12*0x34; pulse start with 0x99*0x99 at cycle 3 of busy -> ignored; product=0x03A8; no second done.
- Start 0x10*0x10, assert reset asynchronously (mid-cycle) at cycle 4 -> busy, done and product go 0 immediately; after release, start 0x02*0x03 -> product=0x0006.
- Hold start=1 continuously with 7*9 then 11*13 presented at the accept edges -> done at cycle 8 (product=0x003F); second run accepted at that done edge; done 8 cycles later with product=0x008F.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } mult_state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage : mult_pkg

// File: rtl/adder8.sv
// Combinational adder/subtractor: control=0 adds, control=1 subtracts.
// Only the low WIDTH bits of the result are produced; no carry-out.
module adder8 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             control,
   output logic [WIDTH-1:0] sum
);

   // Single add or subtract depending on control
   always_comb begin
      if (control) sum = op1 - op2;
      else         sum = op1 + op2;
   end

endmodule : adder8

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier. One partial product is
// accumulated per clock through a shared adder8; the result is ready
// WIDTH clocks after start is accepted.
module shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   mult_state_t        r_state;
   mult_state_t        w_state_nxt;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [CW-1:0]      r_count;
   logic [2*WIDTH-1:0] r_product;

   logic               w_accept;
   logic               w_last;
   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH-1:0]   w_sum;
   logic               w_carry;
   logic [WIDTH-1:0]   w_hi_nxt;
   logic [WIDTH-1:0]   w_lo_nxt;

   // New operation may only be taken while not running
   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last   = (r_count == CNT_LAST);

   // Partial product: multiplicand when the current multiplier bit is set
   assign w_addend = r_lo[0] ? r_mcand : '0;

   adder8 #(
      .WIDTH (WIDTH)
   ) u_add (
      .op1     (r_hi),
      .op2     (w_addend),
      .control (1'b0),
      .sum     (w_sum)
   );

   // adder8 has no carry-out, so recover it from the operand and sum MSBs
   assign w_carry = (r_hi[WIDTH-1] & w_addend[WIDTH-1]) |
                    ((r_hi[WIDTH-1] | w_addend[WIDTH-1]) & ~w_sum[WIDTH-1]);

   // {carry, sum, lo} shifted right by one
   assign w_hi_nxt = {w_carry, w_sum[WIDTH-1:1]};
   assign w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = start ? S_RUN : S_IDLE;
         S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
         S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      busy    = (r_state == S_RUN);
      done    = (r_state == S_DONE);
      product = r_product;
   end

   // Operand capture, shift-and-add step and result latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mcand   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_count   <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_mcand <= op_a;
         r_hi    <= '0;
         r_lo    <= op_b;
         r_count <= CNT_INIT;
      end else if (r_state == S_RUN) begin
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
         r_count <= r_count - CNT_LAST;
         if (w_last) r_product <= {w_hi_nxt, w_lo_nxt};
      end
   end

endmodule : shift_add_mult
